pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Hazard and stall sequencer for the 5-stage MIPS pipeline driven by the pipelined control decoder. It keeps its own shadow of the ID/EX and EX/MEM destination and control bits, and detects load-use hazards. It squashes wrong-path fetches after taken branches and jumps, and freezes the pipe while data memory is not ready. It drives the PC and pipeline-register enables, flushes and bubble-inserts.

Parameters:
REG_AW, 5, register-address width
FLUSH_EXTRA, 1, extra IF/ID flush cycles after a taken branch, beyond the resolving cycle (0..7)
MEM_TIMEOUT, 15, maximum consecutive MEM_WAIT cycles before abort (1..255)

Ports:
clk  in  1  clock
rst_n  in  1  reset
id_valid  in  1  ID holds a real instruction (0 for nop/bubble)
id_rs  in  REG_AW  ID source rs
id_rt  in  REG_AW  ID source rt
id_uses_rt  in  1  ID instruction reads rt (R-format, SW, BEQ)
id_dst  in  REG_AW  ID destination after RegDst mux
id_reg_write  in  1  RegWrite of the ID instruction
id_mem_read  in  1  MemRead of the ID instruction
id_jump  in  1  Jump decoded in ID
ex_branch_taken  in  1  branch resolved taken in EX
dmem_req  in  1  MEM stage accessing data memory
dmem_ready  in  1  data memory completes this cycle
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID register enable
ifid_flush  out  1  IF/ID loads a nop
idex_bubble  out  1  ID/EX loads a nop
pipe_en  out  1  ID/EX, EX/MEM and MEM/WB enable
mem_timeout  out  1  sticky error: memory wait aborted
state  out  2  FSM state, for debug

Behaviour:
- Asynchronous, active-low reset. The design uses one clock; reset is asynchronous and active-low, and the ports are named clk and rst_n.
- Reset values:
  - state=RUN(0).
  - EX/MEM shadows cleared (mem_read=0, reg_write=0, dst=0).
  - flush_cnt=0, wait_cnt=0, mem_timeout=0.
  - With inputs idle, outputs are pc_en=1, ifid_en=1, pipe_en=1, ifid_flush=0, idex_bubble=0.
- Output logic:
  - Outputs are combinational from state plus inputs (Mealy).
  - Registers update on posedge clk.
- States: RUN=0, FLUSH=1, MEM_WAIT=2. Encoding 3 is illegal and goes to RUN.
- Load-use hazard (lu) is true when all of the following hold:
  - ex_mem_read
  - ex_dst != 0
  - id_valid
  - ex_dst==id_rs, or (id_uses_rt and ex_dst==id_rt)
- Priority in RUN, highest first:
  1. dmem_req and not dmem_ready: all enables 0, no flush or bubble. Next state is MEM_WAIT, wait_cnt<=1.
  2. ex_branch_taken: pc_en=1, ifid_flush=1, idex_bubble=1. flush_cnt<=FLUSH_EXTRA. Next state is FLUSH if FLUSH_EXTRA>0.
  3. lu: pc_en=0, ifid_en=0, idex_bubble=1, for exactly 1 cycle. A jump asserted together with lu waits for the stall to clear.
  4. id_jump: ifid_flush=1 for 1 cycle.
- FLUSH state:
  - ifid_flush=1 and idex_bubble=1; the ID content is wrong-path.
  - id_jump and lu are ignored.
  - flush_cnt decrements each cycle; return to RUN after the cycle in which it reaches 1.
  - A new ex_branch_taken reloads flush_cnt.
- MEM_WAIT state:
  - All enables 0; ex_branch_taken and id_jump are ignored (frozen).
  - wait_cnt increments each cycle.
  - When dmem_ready: enables 1 that cycle. Go to FLUSH if flush_cnt!=0, else RUN.
  - A flush interrupted by a memory wait resumes with its remaining count.
  - When wait_cnt==MEM_TIMEOUT and no dmem_ready: set mem_timeout (sticky until reset), force pipe_en=1 for 1 cycle, go to RUN.
- Shadow update, only when pipe_en=1:
  - ex shadow <= ID fields, or zeros if idex_bubble or !id_valid.
  - mem shadow <= ex shadow.
- Reset mid-wait or mid-flush returns to the reset values immediately.

Optional Feature:
HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cycles[15:0], counting cycles with pc_en=0.
  - Adds flush_events[15:0], counting ifid_flush rising edges plus jump flushes.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- LW $t0 in EX (ex_dst=8, ex_mem_read=1), ID reads id_rs=8, id_valid=1 -> exactly 1 cycle of pc_en=0, ifid_en=0, idex_bubble=1; next cycle all enables 1.
- Same as above but ex_dst=0, or id_rt=8 with id_uses_rt=0 -> no stall.
- ex_branch_taken=1 with FLUSH_EXTRA=1 -> ifid_flush=1 for 2 cycles, state RUN→FLUSH→RUN; a simultaneous lu is ignored.
- dmem_req=1 with dmem_ready low for 3 cycles -> pipe_en=pc_en=0 for 3 cycles, then 1 in the ready cycle; an ex_branch_taken held during the wait is acted on after release.
- dmem_ready held low for 15 cycles -> mem_timeout=1 and stays 1; state returns to RUN; cleared only by rst_n=0.
- Branch (FLUSH_EXTRA=2) followed by a memory wait during FLUSH -> after ready, the remaining flush cycles complete, for 3 ifid_flush cycles in total.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard and stall sequencer for a 5-stage MIPS pipeline. It keeps its own
// shadow copy of the ID/EX and EX/MEM destination and control bits and detects
// load-use hazards. It squashes wrong-path fetches after taken branches and
// jumps, and freezes the pipe while data memory is busy.
//
// Optional feature macro: HAZARD_PERF_CNT_EN (adds stall/flush counters).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   id_*                decoded fields of the instruction in ID
//   ex_branch_taken     branch resolved taken in EX
//   dmem_req/dmem_ready MEM stage data-memory handshake
//   pc_en, ifid_en      PC and IF/ID enables
//   ifid_flush          IF/ID loads a nop
//   idex_bubble         ID/EX loads a nop
//   pipe_en             ID/EX, EX/MEM, MEM/WB enable
//   mem_timeout         sticky: a memory wait was aborted
//   state               FSM state (RUN=0, FLUSH=1, MEM_WAIT=2)
//   stall_cycles, flush_events  (HAZARD_PERF_CNT_EN only) saturating counters
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned FLUSH_EXTRA = 1,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_jump,
    input  logic              ex_branch_taken,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              pipe_en,
    output logic              mem_timeout,
    output logic [1:0]        state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0]       stall_cycles,
    output logic [15:0]       flush_events
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    localparam logic [2:0] FLUSH_EXTRA_C = 3'(FLUSH_EXTRA);
    localparam logic [7:0] MEM_TIMEOUT_C = 8'(MEM_TIMEOUT);

    state_e            state_q, state_d;
    logic [2:0]        flush_cnt_q, flush_cnt_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;

    // Shadow of the pipeline control bits (EX and MEM stages)
    logic              ex_mem_read_q, ex_reg_write_q;
    logic [REG_AW-1:0] ex_dst_q;
    logic              mem_mem_read_q, mem_reg_write_q;
    logic [REG_AW-1:0] mem_dst_q;

    logic              lu_s;
    logic              mem_stall_s;
    logic              unused_shadow_s;

    // The MEM-stage shadow and ex reg_write are tracked but not consumed here.
    assign unused_shadow_s = ^{ex_reg_write_q, mem_mem_read_q, mem_reg_write_q, mem_dst_q};

    // Load-use: the load in EX writes a register that ID is about to read.
    assign lu_s = ex_mem_read_q && (ex_dst_q != {REG_AW{1'b0}}) && id_valid &&
                  ((ex_dst_q == id_rs) || (id_uses_rt && (ex_dst_q == id_rt)));

    assign mem_stall_s = dmem_req && !dmem_ready;
    assign mem_timeout = mem_timeout_q;
    assign state       = state_q;

    // Next-state and Mealy output decode
    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        pipe_en       = 1'b1;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_stall_s) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    pipe_en    = 1'b0;
                    wait_cnt_d = 8'd1;
                    state_d    = ST_MEM_WAIT;
                end else if (ex_branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    flush_cnt_d = FLUSH_EXTRA_C;
                    state_d     = (FLUSH_EXTRA_C != 3'd0) ? ST_FLUSH : ST_RUN;
                end else if (lu_s) begin
                    // A jump seen together with lu is retried once the stall clears.
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                end else if (id_jump) begin
                    ifid_flush = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (mem_stall_s) begin
                    // Freeze; flush_cnt is kept so the flush resumes after the wait.
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    pipe_en    = 1'b0;
                    wait_cnt_d = 8'd1;
                    state_d    = ST_MEM_WAIT;
                end else begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (ex_branch_taken) begin
                        flush_cnt_d = FLUSH_EXTRA_C;
                    end else if (flush_cnt_q <= 3'd1) begin
                        flush_cnt_d = 3'd0;
                        state_d     = ST_RUN;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 3'd1;
                    end
                end
            end
            ST_MEM_WAIT: begin
                pc_en   = 1'b0;
                ifid_en = 1'b0;
                pipe_en = 1'b0;
                if (dmem_ready) begin
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    pipe_en    = 1'b1;
                    wait_cnt_d = 8'd0;
                    state_d    = (flush_cnt_q != 3'd0) ? ST_FLUSH : ST_RUN;
                end else if (wait_cnt_q >= MEM_TIMEOUT_C) begin
                    // Abort: drain the back end once and drop any pending flush.
                    pipe_en       = 1'b1;
                    mem_timeout_d = 1'b1;
                    wait_cnt_d    = 8'd0;
                    flush_cnt_d   = 3'd0;
                    state_d       = ST_RUN;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d     = ST_RUN;
                flush_cnt_d = 3'd0;
                wait_cnt_d  = 8'd0;
            end
        endcase
    end

    // FSM state and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            flush_cnt_q   <= 3'd0;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Control shadow advances with the pipe; bubbles and invalid slots load zeros
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_mem_read_q   <= 1'b0;
            ex_reg_write_q  <= 1'b0;
            ex_dst_q        <= {REG_AW{1'b0}};
            mem_mem_read_q  <= 1'b0;
            mem_reg_write_q <= 1'b0;
            mem_dst_q       <= {REG_AW{1'b0}};
        end else if (pipe_en) begin
            if (idex_bubble || !id_valid) begin
                ex_mem_read_q  <= 1'b0;
                ex_reg_write_q <= 1'b0;
                ex_dst_q       <= {REG_AW{1'b0}};
            end else begin
                ex_mem_read_q  <= id_mem_read;
                ex_reg_write_q <= id_reg_write;
                ex_dst_q       <= id_dst;
            end
            mem_mem_read_q  <= ex_mem_read_q;
            mem_reg_write_q <= ex_reg_write_q;
            mem_dst_q       <= ex_dst_q;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cycles_q, flush_events_q;
    logic        ifid_flush_prev_q;
    logic        flush_event_s;

    // A jump flush in RUN is counted even when it follows another flush cycle.
    assign flush_event_s = (ifid_flush && !ifid_flush_prev_q) ||
                           ((state_q == ST_RUN) && ifid_flush && !ex_branch_taken);

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q    <= 16'd0;
            flush_events_q    <= 16'd0;
            ifid_flush_prev_q <= 1'b0;
        end else begin
            ifid_flush_prev_q <= ifid_flush;
            if (!pc_en && (stall_cycles_q != 16'hFFFF)) begin
                stall_cycles_q <= stall_cycles_q + 16'd1;
            end
            if (flush_event_s && (flush_events_q != 16'hFFFF)) begin
                flush_events_q <= flush_events_q + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          id_valid, id_uses_rt, id_reg_write, id_mem_read, id_jump;
    logic [AW-1:0] id_rs, id_rt, id_dst;
    logic          ex_branch_taken, dmem_req, dmem_ready;

    logic          pc_en1, ifid_en1, ifid_flush1, idex_bubble1, pipe_en1, to1;
    logic [1:0]    st1;
    logic          pc_en2, ifid_en2, ifid_flush2, idex_bubble2, pipe_en2, to2;
    logic [1:0]    st2;
    logic [4:0]    o1, o2;

    assign o1 = {pc_en1, ifid_en1, pipe_en1, ifid_flush1, idex_bubble1};
    assign o2 = {pc_en2, ifid_en2, pipe_en2, ifid_flush2, idex_bubble2};

    pipeline_hazard_ctrl #(.REG_AW(AW), .FLUSH_EXTRA(1), .MEM_TIMEOUT(15)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_dst(id_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_jump(id_jump), .ex_branch_taken(ex_branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_en(pc_en1), .ifid_en(ifid_en1),
        .ifid_flush(ifid_flush1), .idex_bubble(idex_bubble1), .pipe_en(pipe_en1),
        .mem_timeout(to1), .state(st1));

    pipeline_hazard_ctrl #(.REG_AW(AW), .FLUSH_EXTRA(2), .MEM_TIMEOUT(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_dst(id_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_jump(id_jump), .ex_branch_taken(ex_branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_en(pc_en2), .ifid_en(ifid_en2),
        .ifid_flush(ifid_flush2), .idex_bubble(idex_bubble2), .pipe_en(pipe_en2),
        .mem_timeout(to2), .state(st2));

    // Reference model: "how many wrong-path cycles remain", "are we waiting on
    // memory and for how long", plus the load currently sitting in EX.
    typedef struct {
        bit in_wait;
        int wait_len;
        int flush_left;
        bit to;
        bit ex_load;
        int ex_dst;
    } mdl_t;

    mdl_t m1, m2;
    int   n_cmp = 0;
    int   n_err = 0;
    int   fl_cnt1, fl_cnt2;
    logic [4:0] last_o1, last_o2;
    logic [1:0] last_st1;
    logic       last_to1;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.in_wait = 1'b0; r.wait_len = 0; r.flush_left = 0;
        r.to = 1'b0; r.ex_load = 1'b0; r.ex_dst = 0;
        return r;
    endfunction

    function automatic int mdl_state(input mdl_t m);
        if (m.in_wait) return 2;
        if (m.flush_left > 0) return 1;
        return 0;
    endfunction

    // One clock of behaviour; o = {pc_en, ifid_en, pipe_en, ifid_flush, idex_bubble}
    function automatic void mdl_step(inout mdl_t m, input int fe, input int mt, output logic [4:0] o);
        bit pc = 1, ifid = 1, pipe = 1, fl = 0, bub = 0;
        bit lu;
        lu = m.ex_load && (m.ex_dst != 0) && id_valid &&
             ((m.ex_dst == int'(id_rs)) || (id_uses_rt && (m.ex_dst == int'(id_rt))));
        if (m.in_wait) begin
            pc = 0; ifid = 0; pipe = 0;
            if (dmem_ready) begin
                pc = 1; ifid = 1; pipe = 1; m.in_wait = 0;
            end else if (m.wait_len == mt) begin
                pipe = 1; m.to = 1; m.in_wait = 0; m.flush_left = 0;
            end else begin
                m.wait_len = m.wait_len + 1;
            end
        end else if (dmem_req && !dmem_ready) begin
            pc = 0; ifid = 0; pipe = 0; m.in_wait = 1; m.wait_len = 1;
        end else if (ex_branch_taken) begin
            fl = 1; bub = 1; m.flush_left = fe;
        end else if (m.flush_left > 0) begin
            fl = 1; bub = 1; m.flush_left = m.flush_left - 1;
        end else if (lu) begin
            pc = 0; ifid = 0; bub = 1;
        end else if (id_jump) begin
            fl = 1;
        end
        if (pipe) begin
            if (bub || !id_valid) begin
                m.ex_load = 0; m.ex_dst = 0;
            end else begin
                m.ex_load = id_mem_read; m.ex_dst = int'(id_dst);
            end
        end
        o = {pc, ifid, pipe, fl, bub};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_dst = '0;
        id_reg_write = 1'b0; id_mem_read = 1'b0; id_jump = 1'b0;
        ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic load_id(input logic [AW-1:0] dst);
        idle();
        id_valid = 1'b1; id_rs = 5'd29; id_dst = dst; id_mem_read = 1'b1; id_reg_write = 1'b1;
    endtask

    // Compare both DUTs against the model for one cycle, then advance a clock.
    task automatic step(input string tag);
        logic [4:0] e1, e2;
        @(negedge clk);
        chk({tag, "/state1"}, 32'(st1), 32'(mdl_state(m1)));
        chk({tag, "/timeout1"}, 32'(to1), 32'(m1.to));
        chk({tag, "/state2"}, 32'(st2), 32'(mdl_state(m2)));
        chk({tag, "/timeout2"}, 32'(to2), 32'(m2.to));
        mdl_step(m1, 1, 15, e1);
        mdl_step(m2, 2, 4, e2);
        chk({tag, "/out1"}, 32'(o1), 32'(e1));
        chk({tag, "/out2"}, 32'(o2), 32'(e2));
        last_o1 = o1; last_o2 = o2; last_st1 = st1; last_to1 = to1;
        fl_cnt1 += int'(ifid_flush1);
        fl_cnt2 += int'(ifid_flush2);
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset: state must clear without waiting for a clock edge.
    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #2;
        chk("rst/state1", 32'(st1), 32'd0);
        chk("rst/timeout1", 32'(to1), 32'd0);
        chk("rst/out1", 32'(o1), 32'h1C);
        chk("rst/state2", 32'(st2), 32'd0);
        chk("rst/timeout2", 32'(to2), 32'd0);
        chk("rst/out2", 32'(o2), 32'h1C);
        m1 = mdl_reset();
        m2 = mdl_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        rst_n = 1'b1;
        fl_cnt1 = 0; fl_cnt2 = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Load-use on rs: exactly one stall cycle
        load_id(5'd8); step("lw");
        idle(); id_valid = 1'b1; id_rs = 5'd8; id_rt = 5'd9; id_uses_rt = 1'b1;
        id_dst = 5'd10; id_reg_write = 1'b1;
        step("lu_stall");
        chk("lu_stall/const", 32'(last_o1), 32'h05);
        step("lu_release");
        chk("lu_release/const", 32'(last_o1), 32'h1C);

        // Load to $zero never stalls
        load_id(5'd0); step("lw_zero");
        idle(); id_valid = 1'b1; id_rs = 5'd0; step("lu_zero");
        chk("lu_zero/const", 32'(last_o1), 32'h1C);

        // rt match without uses_rt never stalls
        load_id(5'd8); step("lw_rt");
        idle(); id_valid = 1'b1; id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b0; step("lu_rt_unused");
        chk("lu_rt_unused/const", 32'(last_o1), 32'h1C);

        // Taken branch beats a simultaneous load-use; FLUSH_EXTRA=1 gives 2 flush cycles
        load_id(5'd8); step("lw_br");
        idle(); id_valid = 1'b1; id_rs = 5'd8; ex_branch_taken = 1'b1; step("br");
        chk("br/const", 32'(last_o1), 32'h1F);
        idle(); id_valid = 1'b1; id_rs = 5'd8; id_jump = 1'b1; step("br_flush");
        chk("br_flush/const", 32'(last_o1), 32'h1F);
        chk("br_flush/state", 32'(last_st1), 32'd1);
        idle(); step("br_done");
        chk("br_done/state", 32'(last_st1), 32'd0);
        step("br_done2");

        // Three-cycle memory wait with a branch held across it
        idle(); dmem_req = 1'b1; ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("mwait");
            chk("mwait/const", 32'(last_o1), 32'h00);
        end
        dmem_ready = 1'b1; step("mready");
        chk("mready/const", 32'(last_o1), 32'h1C);
        idle(); ex_branch_taken = 1'b1; step("br_after_wait");
        chk("br_after_wait/const", 32'(last_o1), 32'h1F);
        idle();
        for (int i = 0; i < 3; i++) step("settle");

        // Timeout: 15 wait cycles after entry, then sticky flag
        idle(); dmem_req = 1'b1;
        for (int i = 0; i < 16; i++) step("timeout_wait");
        chk("timeout_abort/const", 32'(last_o1), 32'h04);
        idle();
        for (int i = 0; i < 4; i++) begin
            step("timeout_sticky");
            chk("timeout_sticky/const", 32'(last_to1), 32'd1);
            chk("timeout_state/const", 32'(last_st1), 32'd0);
        end
        do_reset();

        // Branch, then a memory wait interrupts FLUSH; the flush resumes afterwards
        fl_cnt1 = 0; fl_cnt2 = 0;
        idle(); ex_branch_taken = 1'b1; step("br2");
        idle(); dmem_req = 1'b1; step("br2_wait");
        dmem_ready = 1'b1; step("br2_ready");
        idle();
        for (int i = 0; i < 4; i++) step("br2_resume");
        chk("flush_total_fe1", 32'(fl_cnt1), 32'd2);
        chk("flush_total_fe2", 32'(fl_cnt2), 32'd3);

        // Randomised traffic with small register numbers to provoke hazards
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) == 0) begin
                do_reset();
            end
            id_valid        = ($urandom_range(3) != 0);
            id_rs           = 5'($urandom_range(3));
            id_rt           = 5'($urandom_range(3));
            id_uses_rt      = 1'($urandom_range(1));
            id_dst          = 5'($urandom_range(3));
            id_reg_write    = 1'($urandom_range(1));
            id_mem_read     = ($urandom_range(2) == 0);
            id_jump         = ($urandom_range(6) == 0);
            ex_branch_taken = ($urandom_range(9) == 0);
            dmem_req        = ($urandom_range(3) == 0);
            dmem_ready      = ($urandom_range(2) == 0);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
